// File: rtl/harvard_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
// Module : harvard_ctrl_seq_if
// Brief  : Instruction/data/accumulator/status bus of the Harvard sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
interface harvard_ctrl_seq_if #(
   parameter int PC_W   = 8,
   parameter int DATA_W = 16,
   parameter int INSN_W = 22
) ();
   logic [INSN_W-1:0] I;
   logic [PC_W-1:0]   PC;
   logic [PC_W-1:0]   DWA;
   logic [DATA_W-1:0] DW;
   logic              d_we;
   logic [DATA_W-1:0] DR;
   logic [DATA_W-1:0] AW;
   logic              a_we;
   logic [DATA_W-1:0] AR;
   logic              EFW;
   logic              CFW;
   logic              EFF;
   logic              CFF;

   modport master (
      input  I, DR, AR, EFF, CFF,
      output PC, DWA, DW, d_we, AW, a_we, EFW, CFW
   );

   modport slave (
      output I, DR, AR, EFF, CFF,
      input  PC, DWA, DW, d_we, AW, a_we, EFW, CFW
   );
endinterface
`default_nettype wire

// File: rtl/harvard_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module : harvard_ctrl_seq
// Brief  : Two-cycle fetch/execute sequencer with 16-bit ALU. Optional macro
//          ILLEGAL_OP_TRAP_EN halts on opcodes B-E instead of treating as NOP.
// Rev    : 1.0 - initial release
// ============================================================================
module harvard_ctrl_seq #(
   parameter int PC_W     = 8,
   parameter int DATA_W   = 16,
   parameter int INSN_W   = 22,
   parameter int RESET_PC = 0
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     run,
   harvard_ctrl_seq_if.master       bus,
   output logic                     halted,
   output logic                     busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [3:0] c_op_nop = 4'h0;
   localparam logic [3:0] c_op_ldi = 4'h1;
   localparam logic [3:0] c_op_lda = 4'h2;
   localparam logic [3:0] c_op_sta = 4'h3;
   localparam logic [3:0] c_op_add = 4'h4;
   localparam logic [3:0] c_op_sub = 4'h5;
   localparam logic [3:0] c_op_and = 4'h6;
   localparam logic [3:0] c_op_or  = 4'h7;
   localparam logic [3:0] c_op_jmp = 4'h8;
   localparam logic [3:0] c_op_jz  = 4'h9;
   localparam logic [3:0] c_op_jc  = 4'hA;
   localparam logic [3:0] c_op_hlt = 4'hF;
   localparam logic [PC_W-1:0] c_reset_pc = PC_W'(RESET_PC);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PC_W-1:0]     r_pc;
   logic [PC_W-1:0]     w_pc_nxt;
   logic [INSN_W-1:0]   r_ir;

   logic [3:0]          w_op;
   logic [PC_W-1:0]     w_n;
   logic [DATA_W-1:0]   w_imm;
   logic [DATA_W:0]     w_sum;
   logic [DATA_W:0]     w_diff;
   logic [DATA_W-1:0]   w_alu;
   logic                w_a_we;
   logic                w_d_we;
   logic                w_efw;
   logic                w_cfw;
   logic                w_unused_rsvd;

   assign w_op          = r_ir[INSN_W-1 -: 4];
   assign w_n           = r_ir[PC_W-1:0];
   assign w_imm         = r_ir[DATA_W-1:0];
   assign w_unused_rsvd = ^r_ir[INSN_W-5 -: 2];

   // Top bit of the 17-bit difference is the borrow (set when A < M).
   assign w_sum  = {1'b0, bus.AR} + {1'b0, bus.DR};
   assign w_diff = {1'b0, bus.AR} - {1'b0, bus.DR};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
         r_pc    <= c_reset_pc;
         r_ir    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         if (r_state == S_FETCH) begin
            r_ir <= bus.I;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_alu       = '0;
      w_a_we      = 1'b0;
      w_d_we      = 1'b0;
      w_efw       = bus.EFF;
      w_cfw       = bus.CFF;

      case (r_state)
         S_IDLE: begin
            if (run) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = r_pc + 1'b1;
            case (w_op)
               c_op_nop: begin
               end
               c_op_ldi: begin
                  w_alu  = w_imm;
                  w_a_we = 1'b1;
               end
               c_op_lda: begin
                  w_alu  = bus.DR;
                  w_a_we = 1'b1;
               end
               c_op_sta: begin
                  w_d_we = 1'b1;
               end
               c_op_add: begin
                  w_alu  = w_sum[DATA_W-1:0];
                  w_cfw  = w_sum[DATA_W];
                  w_a_we = 1'b1;
               end
               c_op_sub: begin
                  w_alu  = w_diff[DATA_W-1:0];
                  w_cfw  = w_diff[DATA_W];
                  w_a_we = 1'b1;
               end
               c_op_and: begin
                  w_alu  = bus.AR & bus.DR;
                  w_cfw  = 1'b0;
                  w_a_we = 1'b1;
               end
               c_op_or: begin
                  w_alu  = bus.AR | bus.DR;
                  w_cfw  = 1'b0;
                  w_a_we = 1'b1;
               end
               c_op_jmp: begin
                  w_pc_nxt = w_n;
               end
               c_op_jz: begin
                  if (bus.EFF) begin
                     w_pc_nxt = w_n;
                  end
               end
               c_op_jc: begin
                  if (bus.CFF) begin
                     w_pc_nxt = w_n;
                  end
               end
               c_op_hlt: begin
                  w_state_nxt = S_HALT;
                  w_pc_nxt    = r_pc;
               end
               default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                  w_state_nxt = S_HALT;
                  w_pc_nxt    = r_pc;
`endif
               end
            endcase
            if (w_a_we) begin
               w_efw = (w_alu == '0);
            end
         end
         default: begin
         end
      endcase
   end

   assign bus.PC   = r_pc;
   assign bus.DWA  = r_ir[PC_W-1:0];
   assign bus.DW   = bus.AR;
   assign bus.d_we = w_d_we;
   assign bus.AW   = w_alu;
   assign bus.a_we = w_a_we;
   // The status store latches every edge, so reset must present cleared flags.
   assign bus.EFW  = RST_N & w_efw;
   assign bus.CFW  = RST_N & w_cfw;

   assign halted = (r_state == S_HALT);
   assign busy   = (r_state == S_FETCH) || (r_state == S_EXEC);

endmodule
`default_nettype wire

// File: tb/tb_harvard_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_harvard_ctrl_seq
// Brief  : Instruction-level reference model bench with directed and random programs.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_harvard_ctrl_seq;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;
   logic run   = 1'b0;
   logic halted;
   logic busy;
   logic load  = 1'b0;

   harvard_ctrl_seq_if bus ();

   harvard_ctrl_seq dut (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .run    (run),
      .bus    (bus),
      .halted (halted),
      .busy   (busy)
   );

   always #5 CLK = ~CLK;

   logic [21:0] imem  [256];
   logic [15:0] dinit [256];
   logic [15:0] dmem  [256];
   logic [15:0] acc;
   logic        ef;
   logic        cf;

   assign bus.I   = imem[bus.PC];
   assign bus.DR  = dmem[bus.DWA];
   assign bus.AR  = acc;
   assign bus.EFF = ef;
   assign bus.CFF = cf;

   always @(posedge CLK) begin
      if (load) begin
         for (int i = 0; i < 256; i++) dmem[i] <= dinit[i];
      end else if (bus.d_we) begin
         dmem[bus.DWA] <= bus.DW;
      end
      ef <= bus.EFW;
      cf <= bus.CFW;
   end

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) acc <= 16'h0;
      else if (bus.a_we) acc <= bus.AW;
   end

   // Reference model: 0 idle, 1 fetch, 2 execute, 3 halted
   int          m_mode;
   logic [7:0]  m_pc;
   logic [21:0] m_ir;
   logic [15:0] m_acc;
   logic        m_ef;
   logic        m_cf;
   logic [15:0] m_mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [21:0] ins(input logic [3:0] op, input logic [15:0] v);
      return {op, 2'b00, v};
   endfunction

   task automatic do_reset(input bit reload);
      RST_N  = 1'b0;
      run    = 1'b0;
      load   = reload;
      m_mode = 0;
      m_pc   = 8'h00;
      m_ir   = 22'h0;
      m_acc  = 16'h0;
      m_ef   = 1'b0;
      m_cf   = 1'b0;
      if (reload) for (int i = 0; i < 256; i++) m_mem[i] = dinit[i];
      repeat (2) @(negedge CLK);
      load = 1'b0;
      chk("rst_pc",     32'(bus.PC),   32'h0);
      chk("rst_busy",   32'(busy),     32'h0);
      chk("rst_halted", 32'(halted),   32'h0);
      chk("rst_d_we",   32'(bus.d_we), 32'h0);
      chk("rst_a_we",   32'(bus.a_we), 32'h0);
      chk("rst_efw",    32'(bus.EFW),  32'h0);
      chk("rst_cfw",    32'(bus.CFW),  32'h0);
      RST_N = 1'b1;
   endtask

   // One clock: compare DUT outputs against the model, then advance the model.
   task automatic cycle(input logic r);
      logic        e_dwe, e_awe, e_efw, e_cfw;
      logic [15:0] e_aw, a, mv;
      logic [7:0]  nxt_pc, n;
      logic [3:0]  op;
      int          nxt_mode, s;
      @(negedge CLK);
      run      = r;
      e_dwe    = 1'b0;
      e_awe    = 1'b0;
      e_efw    = m_ef;
      e_cfw    = m_cf;
      e_aw     = 16'h0;
      nxt_pc   = m_pc;
      nxt_mode = m_mode;
      n        = m_ir[7:0];
      op       = m_ir[21:18];
      a        = m_acc;
      mv       = m_mem[n];
      if (m_mode == 0) begin
         if (r) nxt_mode = 1;
      end else if (m_mode == 1) begin
         nxt_mode = 2;
      end else if (m_mode == 2) begin
         nxt_mode = 1;
         nxt_pc   = m_pc + 8'd1;
         case (op)
            4'h1: begin e_awe = 1'b1; e_aw = m_ir[15:0]; end
            4'h2: begin e_awe = 1'b1; e_aw = mv; end
            4'h3: e_dwe = 1'b1;
            4'h4: begin
               s = int'(a) + int'(mv);
               e_awe = 1'b1; e_aw = 16'(s % 65536); e_cfw = (s > 65535);
            end
            4'h5: begin
               s = int'(a) - int'(mv);
               e_awe = 1'b1; e_aw = 16'((s + 65536) % 65536); e_cfw = (s < 0);
            end
            4'h6: begin e_awe = 1'b1; e_aw = a & mv; e_cfw = 1'b0; end
            4'h7: begin e_awe = 1'b1; e_aw = a | mv; e_cfw = 1'b0; end
            4'h8: nxt_pc = n;
            4'h9: if (m_ef) nxt_pc = n;
            4'hA: if (m_cf) nxt_pc = n;
            4'hF: begin nxt_mode = 3; nxt_pc = m_pc; end
            4'hB, 4'hC, 4'hD, 4'hE: begin
`ifdef ILLEGAL_OP_TRAP_EN
               nxt_mode = 3; nxt_pc = m_pc;
`endif
            end
            default: ;
         endcase
         if (e_awe) e_efw = (e_aw == 16'h0);
      end

      chk("pc",     32'(bus.PC),   32'(m_pc));
      chk("busy",   32'(busy),     32'(m_mode == 1 || m_mode == 2));
      chk("halted", 32'(halted),   32'(m_mode == 3));
      chk("d_we",   32'(bus.d_we), 32'(e_dwe));
      chk("a_we",   32'(bus.a_we), 32'(e_awe));
      chk("efw",    32'(bus.EFW),  32'(e_efw));
      chk("cfw",    32'(bus.CFW),  32'(e_cfw));
      chk("acc",    32'(acc),      32'(m_acc));
      chk("eff",    32'(ef),       32'(m_ef));
      chk("cff",    32'(cf),       32'(m_cf));
      if (e_awe) chk("aw", 32'(bus.AW), 32'(e_aw));
      if (e_dwe) begin
         chk("dwa", 32'(bus.DWA), 32'(n));
         chk("dw",  32'(bus.DW),  32'(m_acc));
      end

      if (m_mode == 1) m_ir = imem[m_pc];
      if (e_dwe) m_mem[n] = m_acc;
      if (e_awe) m_acc = e_aw;
      m_ef   = e_efw;
      m_cf   = e_cfw;
      m_pc   = nxt_pc;
      m_mode = nxt_mode;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) begin
         imem[i]  = ins(4'hF, 16'h0);
         dinit[i] = 16'h0;
      end
   endtask

   task automatic run_cycles(input int k);
      cycle(1'b1);
      for (int i = 1; i < k; i++) cycle(1'(($urandom_range(0, 1))));
   endtask

   task automatic check_mem(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (dmem[i] !== m_mem[i]) bad++;
      chk(name, 32'(bad), 32'h0);
   endtask

   initial begin
      // LDI 0x1234 then HLT
      clear_prog();
      imem[0] = ins(4'h1, 16'h1234);
      imem[1] = ins(4'hF, 16'h0);
      do_reset(1'b1);
      run_cycles(10);
      chk("ldi_acc", 32'(acc), 32'h1234);
      chk("ldi_ef",  32'(ef),  32'h0);
      chk("ldi_pc",  32'(bus.PC), 32'h1);

      // 1 + 0xFFFF wraps to zero with carry
      clear_prog();
      dinit[5] = 16'hFFFF;
      imem[0]  = ins(4'h1, 16'h0001);
      imem[1]  = ins(4'h4, 16'h0005);
      do_reset(1'b1);
      run_cycles(12);
      chk("add_acc", 32'(acc), 32'h0);
      chk("add_ef",  32'(ef),  32'h1);
      chk("add_cf",  32'(cf),  32'h1);

      // 3 - 5 borrows; JC taken, JZ not taken
      clear_prog();
      dinit[6]   = 16'h0005;
      imem[0]    = ins(4'h1, 16'h0003);
      imem[1]    = ins(4'h5, 16'h0006);
      imem[2]    = ins(4'hA, 16'h0020);
      imem[8'h20] = ins(4'h9, 16'h0030);
      do_reset(1'b1);
      run_cycles(16);
      chk("sub_acc", 32'(acc), 32'hFFFE);
      chk("sub_cf",  32'(cf),  32'h1);
      chk("sub_ef",  32'(ef),  32'h0);
      chk("br_pc",   32'(bus.PC), 32'h21);

      // STA, then run ignored while halted
      clear_prog();
      imem[0] = ins(4'h1, 16'hBEEF);
      imem[1] = ins(4'h3, 16'h0010);
      do_reset(1'b1);
      run_cycles(12);
      chk("sta_mem", 32'(dmem[16]), 32'hBEEF);
      for (int i = 0; i < 6; i++) cycle(1'b1);
      chk("hlt_pc",     32'(bus.PC), 32'h2);
      chk("hlt_halted", 32'(halted), 32'h1);

      // PC wrap 255 -> 0
      clear_prog();
      imem[0]     = ins(4'h9, 16'h0005);
      imem[1]     = ins(4'h8, 16'h00FF);
      imem[8'hFF] = ins(4'h1, 16'h0000);
      do_reset(1'b1);
      run_cycles(20);
      chk("wrap_pc", 32'(bus.PC), 32'h5);

      // Opcode 0xC
      clear_prog();
      imem[0] = ins(4'hC, 16'h0007);
      do_reset(1'b1);
      run_cycles(10);
`ifdef ILLEGAL_OP_TRAP_EN
      chk("ill_pc", 32'(bus.PC), 32'h0);
`else
      chk("ill_pc", 32'(bus.PC), 32'h1);
`endif
      chk("ill_halted", 32'(halted), 32'h1);

      // Reset asserted mid-EXEC of STA
      clear_prog();
      imem[0] = ins(4'h1, 16'hBEEF);
      imem[1] = ins(4'h3, 16'h0010);
      do_reset(1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1);
      @(negedge CLK);
      chk("mid_dwe_pre", 32'(bus.d_we), 32'h1);
      chk("mid_dw_pre",  32'(bus.DW),   32'hBEEF);
      RST_N = 1'b0;
      #1;
      chk("mid_dwe", 32'(bus.d_we), 32'h0);
      chk("mid_pc",  32'(bus.PC),   32'h0);
      chk("mid_efw", 32'(bus.EFW),  32'h0);
      do_reset(1'b0);
      chk("mid_mem", 32'(dmem[16]), 32'h0);

      // Random programs
      for (int ep = 0; ep < 10; ep++) begin
         for (int i = 0; i < 256; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 9) != 0) op = 4'h0;
            imem[i]  = {op, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535))};
            dinit[i] = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 7) == 0) dinit[i] = 16'h0;
         end
         do_reset(1'b1);
         for (int i = 0; i < 3; i++) cycle(1'b0);
         run_cycles(300);
         check_mem("rand_mem");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
